// File: rtl/thread_fetch_sched.sv
// Round-robin multithreaded fetch scheduler with per-thread PCs and branch redirect/flush; outputs registered, frozen when en=0.
// Define THREAD_FETCH_SCHED_SKIP_EN for work-conserving selection; default build is strict barrel rotation.
module thread_fetch_sched #(
  parameter int INST_ADDR_WIDTH = 9,
  parameter int THREAD_BITS     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [(2**THREAD_BITS)-1:0]  thread_active,
  input  logic [(2**THREAD_BITS)-1:0]  thread_ready,
  input  logic                         beq,
  input  logic                         bneq,
  input  logic                         zero,
  input  logic [INST_ADDR_WIDTH-1:0]   branch_target,
  input  logic [THREAD_BITS-1:0]       br_thread_id,
  output logic                         fetch_valid,
  output logic [INST_ADDR_WIDTH-1:0]   fetch_pc,
  output logic [THREAD_BITS-1:0]       fetch_thread,
  output logic                         flush,
  output logic [THREAD_BITS-1:0]       flush_thread
);

  localparam int NUM_THREADS = 2**THREAD_BITS;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_RUN  = 2'd1,
    TS_WAIT = 2'd2
  } thr_state_e;

  logic [INST_ADDR_WIDTH-1:0] r_pc [NUM_THREADS];
  logic [THREAD_BITS-1:0]     r_last;
  logic                       r_fetch_valid;
  logic [INST_ADDR_WIDTH-1:0] r_fetch_pc;
  logic [THREAD_BITS-1:0]     r_fetch_thread;
  logic                       r_flush;
  logic [THREAD_BITS-1:0]     r_flush_thread;

  thr_state_e                 w_state [NUM_THREADS];
  logic [NUM_THREADS-1:0]     w_elig;
  logic [THREAD_BITS-1:0]     w_sel;
  logic                       w_grant;
  logic [THREAD_BITS-1:0]     w_last_nxt;
  logic                       w_taken;
  logic                       w_bypass;
  logic [INST_ADDR_WIDTH-1:0] w_fetch_pc;
  logic [INST_ADDR_WIDTH-1:0] w_pc_inc;

  // Thread state is purely a function of this cycle's inputs; only RUN threads may fetch.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_state[i] = TS_IDLE;
      if (thread_active[i]) begin
        w_state[i] = thread_ready[i] ? TS_RUN : TS_WAIT;
      end
      w_elig[i] = (w_state[i] == TS_RUN);
    end
  end

`ifdef THREAD_FETCH_SCHED_SKIP_EN
  always_comb begin
    logic [THREAD_BITS-1:0] v_cand;
    w_sel   = r_last;
    w_grant = 1'b0;
    v_cand  = r_last;
    // k = NUM_THREADS wraps back onto r_last, giving it lowest priority.
    for (int k = 1; k <= NUM_THREADS; k++) begin
      v_cand = r_last + THREAD_BITS'(k);
      if (!w_grant && w_elig[v_cand]) begin
        w_grant = 1'b1;
        w_sel   = v_cand;
      end
    end
    w_last_nxt = w_grant ? w_sel : r_last;
  end
`else
  always_comb begin
    w_sel      = r_last + THREAD_BITS'(1);
    w_grant    = w_elig[w_sel];
    w_last_nxt = w_sel;
  end
`endif

  always_comb begin
    w_taken    = (beq & zero) | (bneq & ~zero);
    w_bypass   = w_taken && w_grant && (br_thread_id == w_sel);
    w_fetch_pc = w_bypass ? branch_target : r_pc[w_sel];
    w_pc_inc   = w_fetch_pc + INST_ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_pc[i] <= '0;
      end
      r_last <= THREAD_BITS'(NUM_THREADS - 1);
    end else if (en) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        // A granted thread always advances past what it fetched, which already includes any bypassed redirect.
        if (w_grant && (w_sel == THREAD_BITS'(i))) begin
          r_pc[i] <= w_pc_inc;
        end else if (w_taken && (br_thread_id == THREAD_BITS'(i))) begin
          r_pc[i] <= branch_target;
        end
      end
      r_last <= w_last_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_valid  <= 1'b0;
      r_fetch_pc     <= '0;
      r_fetch_thread <= '0;
      r_flush        <= 1'b0;
      r_flush_thread <= '0;
    end else if (en) begin
      r_fetch_valid <= w_grant;
      if (w_grant) begin
        r_fetch_pc     <= w_fetch_pc;
        r_fetch_thread <= w_sel;
      end
      r_flush <= w_taken;
      if (w_taken) begin
        r_flush_thread <= br_thread_id;
      end
    end
  end

  assign fetch_valid  = r_fetch_valid;
  assign fetch_pc     = r_fetch_pc;
  assign fetch_thread = r_fetch_thread;
  assign flush        = r_flush;
  assign flush_thread = r_flush_thread;

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Directed bench: stimulus queues hand-computed per-cycle expectations, a monitor pops and compares after each edge.
module tb_thread_fetch_sched;

  logic       clk = 1'b0;
  logic       reset, en;
  logic [3:0] act, rdy;
  logic       beq, bneq, zero;
  logic [8:0] tgt;
  logic [1:0] bid;
  logic       fv;
  logic [8:0] fpc;
  logic [1:0] fth;
  logic       fl;
  logic [1:0] flt;

  always #5 clk = ~clk;

  thread_fetch_sched #(.INST_ADDR_WIDTH(9), .THREAD_BITS(2)) dut (
    .clk(clk), .reset(reset), .en(en),
    .thread_active(act), .thread_ready(rdy),
    .beq(beq), .bneq(bneq), .zero(zero),
    .branch_target(tgt), .br_thread_id(bid),
    .fetch_valid(fv), .fetch_pc(fpc), .fetch_thread(fth),
    .flush(fl), .flush_thread(flt)
  );

  typedef struct packed {
    logic       v;
    logic [8:0] pc;
    logic [1:0] th;
    logic       fl;
    logic [1:0] ft;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  initial begin
    forever begin : mon
      exp_t  e;
      exp_t  a;
      string n;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a.v = fv; a.pc = fpc; a.th = fth; a.fl = fl; a.ft = flt;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got v=%0b pc=%03h th=%0d fl=%0b ft=%0d, expected v=%0b pc=%03h th=%0d fl=%0b ft=%0d",
                   n, a.v, a.pc, a.th, a.fl, a.ft, e.v, e.pc, e.th, e.fl, e.ft);
        end
      end
    end
  end

  task automatic cyc(input string n, input logic r, input logic e_i,
                     input logic [3:0] a_i, input logic [3:0] rd_i,
                     input logic bq, input logic bn, input logic z,
                     input logic [8:0] t, input logic [1:0] b,
                     input logic ev, input logic [8:0] epc, input logic [1:0] eth,
                     input logic efl, input logic [1:0] eft);
    exp_t x;
    @(negedge clk);
    reset = r; en = e_i; act = a_i; rdy = rd_i;
    beq = bq; bneq = bn; zero = z; tgt = t; bid = b;
    x.v = ev; x.pc = epc; x.th = eth; x.fl = efl; x.ft = eft;
    exp_q.push_back(x);
    name_q.push_back(n);
  endtask

  task automatic go(input string n, input logic [3:0] a_i, input logic [3:0] rd_i,
                    input logic ev, input logic [8:0] epc, input logic [1:0] eth,
                    input logic efl, input logic [1:0] eft);
    cyc(n, 1'b1, 1'b1, a_i, rd_i, 1'b0, 1'b0, 1'b0, 9'h000, 2'd0, ev, epc, eth, efl, eft);
  endtask

  initial begin
    int n2;
    int v2[8];
    int t2[8];
    int p2[8];
    reset = 1'b0; en = 1'b0; act = 4'h0; rdy = 4'h0;
    beq = 1'b0; bneq = 1'b0; zero = 1'b0; tgt = 9'h000; bid = 2'd0;

    cyc("reset", 1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 9'h000, 2'd0, 1'b0, 9'h000, 2'd0, 1'b0, 2'd0);

    for (int i = 0; i < 8; i++) begin
      go($sformatf("rr%0d", i), 4'hF, 4'hF, 1'b1, 9'(i / 4), 2'(i % 4), 1'b0, 2'd0);
    end

`ifdef THREAD_FETCH_SCHED_SKIP_EN
    n2 = 6;
    v2 = '{1, 1, 1, 1, 1, 1, 0, 0};
    t2 = '{0, 1, 3, 0, 1, 3, 0, 0};
    p2 = '{2, 2, 2, 3, 3, 3, 0, 0};
`else
    n2 = 8;
    v2 = '{1, 1, 0, 1, 1, 1, 0, 1};
    t2 = '{0, 1, 1, 3, 0, 1, 1, 3};
    p2 = '{2, 2, 2, 2, 3, 3, 3, 3};
`endif
    for (int i = 0; i < n2; i++) begin
      go($sformatf("wait2_%0d", i), 4'hF, 4'b1011, 1'(v2[i]), 9'(p2[i]), 2'(t2[i]), 1'b0, 2'd0);
    end

    cyc("br_issue", 1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 9'h040, 2'd1, 1'b1, 9'h004, 2'd0, 1'b1, 2'd1);
    go("br_tgt",  4'hF, 4'hF, 1'b1, 9'h040, 2'd1, 1'b0, 2'd1);
    go("br_t2",   4'hF, 4'hF, 1'b1, 9'h002, 2'd2, 1'b0, 2'd1);
    go("br_t3",   4'hF, 4'hF, 1'b1, 9'h004, 2'd3, 1'b0, 2'd1);
    go("br_t0",   4'hF, 4'hF, 1'b1, 9'h005, 2'd0, 1'b0, 2'd1);
    go("br_seq",  4'hF, 4'hF, 1'b1, 9'h041, 2'd1, 1'b0, 2'd1);

    cyc("bypass", 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 9'h1FF, 2'd2, 1'b1, 9'h1FF, 2'd2, 1'b1, 2'd2);
    go("byp_t3",  4'hF, 4'hF, 1'b1, 9'h005, 2'd3, 1'b0, 2'd2);
    go("byp_t0",  4'hF, 4'hF, 1'b1, 9'h006, 2'd0, 1'b0, 2'd2);
    go("byp_t1",  4'hF, 4'hF, 1'b1, 9'h042, 2'd1, 1'b0, 2'd2);
    go("wrap",    4'hF, 4'hF, 1'b1, 9'h000, 2'd2, 1'b0, 2'd2);

    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("freeze%0d", i), 1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 9'h100, 2'd0,
          1'b1, 9'h000, 2'd2, 1'b0, 2'd2);
    end
    cyc("br_apply", 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 9'h100, 2'd0, 1'b1, 9'h006, 2'd3, 1'b1, 2'd0);
    cyc("fl_hold",  1'b1, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 9'h000, 2'd0, 1'b1, 9'h006, 2'd3, 1'b1, 2'd0);
    go("apply_t0", 4'hF, 4'hF, 1'b1, 9'h100, 2'd0, 1'b0, 2'd0);
    go("apply_t1", 4'hF, 4'hF, 1'b1, 9'h043, 2'd1, 1'b0, 2'd0);

    cyc("mid_rst", 1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 9'h055, 2'd1, 1'b0, 9'h000, 2'd0, 1'b0, 2'd0);
    go("post_rst0", 4'hF, 4'hF, 1'b1, 9'h000, 2'd0, 1'b0, 2'd0);
    go("post_rst1", 4'hF, 4'hF, 1'b1, 9'h000, 2'd1, 1'b0, 2'd0);

    cyc("idle_br", 1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 9'h020, 2'd3, 1'b0, 9'h000, 2'd1, 1'b1, 2'd3);
`ifdef THREAD_FETCH_SCHED_SKIP_EN
    go("idle_nx0", 4'hF, 4'hF, 1'b1, 9'h000, 2'd2, 1'b0, 2'd3);
    go("idle_nx1", 4'hF, 4'hF, 1'b1, 9'h020, 2'd3, 1'b0, 2'd3);
`else
    go("idle_nx0", 4'hF, 4'hF, 1'b1, 9'h020, 2'd3, 1'b0, 2'd3);
    go("idle_nx1", 4'hF, 4'hF, 1'b1, 9'h001, 2'd0, 1'b0, 2'd3);
`endif

    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
